// File: rtl/router_reg_param.sv
// router_reg_param: register stage between the router FSM and the per-port output FIFOs.
// It captures the packet header and forwards payload bytes to the FIFO. Bytes that arrive
// while the selected FIFO is full are parked in a small circular skid buffer and drained
// during laf_state. A running checksum of the header and payload is compared with the
// trailing parity byte.
//
// Ports:
//   clk, rst              clock (rising edge); synchronous active-low reset
//   pkt_valid             source byte valid (low during the parity byte)
//   fifo_full             selected output FIFO is full
//   rst_int_reg           clears low_pkt_valid
//   detect_add, lfd_state, ld_state, laf_state, full_state   FSM state decodes
//   data_in  [DATA_W]     input byte
//   dout     [DATA_W]     byte to the FIFO; dout_vld is its write strobe
//   parity_done           parity byte has been processed
//   low_pkt_valid         parity byte was seen on the previous cycle
//   err                   checksum mismatch or skid overflow
//   skid_cnt              skid buffer occupancy; skid_ovf is the sticky overflow flag
module router_reg_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int NUM_PORTS  = 3,
  parameter int SKID_DEPTH = 2,
  parameter int CHK_MODE   = 0,
  localparam int CNT_W     = $clog2(SKID_DEPTH + 1),
  localparam int PTR_W     = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic [CNT_W-1:0]  skid_cnt,
  output logic              skid_ovf
);

  logic [DATA_W-1:0] header_q, header_d;
  logic [DATA_W-1:0] int_q, int_d;
  logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              parity_done_q, parity_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              err_q, err_d;
  logic              skid_ovf_q, skid_ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] skid_mem_q [SKID_DEPTH];
  logic [DATA_W-1:0] skid_mem_d [SKID_DEPTH];

  logic addr_ok;
  logic pd_set;

  function automatic logic [DATA_W-1:0] csum(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    if (CHK_MODE == 1) return a + b;  // wraps mod 2^DATA_W
    else               return a ^ b;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(SKID_DEPTH - 1)) return '0;
    else                             return p + PTR_W'(1);
  endfunction

  assign addr_ok = int'(data_in[ADDR_W-1:0]) < NUM_PORTS;

  always_comb begin
    header_d        = header_q;
    int_d           = int_q;
    pkt_par_d       = pkt_par_q;
    dout_d          = dout_q;
    dout_vld_d      = 1'b0;
    parity_done_d   = parity_done_q;
    err_d           = err_q;
    skid_ovf_d      = skid_ovf_q;
    cnt_d           = cnt_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    skid_mem_d      = skid_mem_q;

    low_pkt_valid_d = rst_int_reg ? 1'b0 : (ld_state && !pkt_valid);
    pd_set          = (ld_state && !pkt_valid && !fifo_full) ||
                      (laf_state && low_pkt_valid_q && !parity_done_q);

    if (detect_add) begin
      if (pkt_valid && addr_ok) header_d = data_in;
      int_d         = '0;
      pkt_par_d     = '0;
      parity_done_d = 1'b0;
      err_d         = 1'b0;
      skid_ovf_d    = 1'b0;
      cnt_d         = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end else begin
      // ld_state outranks laf_state, so a push cycle never also pops
      if (lfd_state) begin
        dout_d     = header_q;
        dout_vld_d = 1'b1;
      end else if (ld_state && !fifo_full) begin
        dout_d     = data_in;
        dout_vld_d = 1'b1;
      end else if (ld_state) begin
        if (cnt_q == CNT_W'(SKID_DEPTH)) begin
          skid_ovf_d = 1'b1;  // byte is dropped
        end else begin
          skid_mem_d[wr_ptr_q] = data_in;
          wr_ptr_d             = ptr_inc(wr_ptr_q);
          cnt_d                = cnt_q + CNT_W'(1);
        end
      end else if (laf_state && cnt_q != '0) begin
        dout_d     = skid_mem_q[rd_ptr_q];
        dout_vld_d = 1'b1;
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        cnt_d      = cnt_q - CNT_W'(1);
      end

      if (lfd_state) int_d = csum(int_q, header_q);
      // bytes parked in the skid buffer still count toward the checksum
      if (pkt_valid && ld_state && !full_state) int_d = csum(int_d, data_in);
      if (ld_state && !pkt_valid) pkt_par_d = data_in;
      if (parity_done_q) err_d = (pkt_par_q != int_q) | skid_ovf_q;
    end

    // a parity_done set wins over the detect_add clear
    if (pd_set) parity_done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      header_q        <= '0;
      int_q           <= '0;
      pkt_par_q       <= '0;
      dout_q          <= '0;
      dout_vld_q      <= 1'b0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
      skid_ovf_q      <= 1'b0;
      cnt_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      skid_mem_q      <= '{default: '0};
    end else begin
      header_q        <= header_d;
      int_q           <= int_d;
      pkt_par_q       <= pkt_par_d;
      dout_q          <= dout_d;
      dout_vld_q      <= dout_vld_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
      skid_ovf_q      <= skid_ovf_d;
      cnt_q           <= cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      skid_mem_q      <= skid_mem_d;
    end
  end

  assign dout          = dout_q;
  assign dout_vld      = dout_vld_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;
  assign skid_cnt      = cnt_q;
  assign skid_ovf      = skid_ovf_q;

endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param. It drives two instances from the same control stream:
//   a: defaults (8-bit, XOR, skid depth 2)
//   b: 16-bit, additive checksum, skid depth 3
// Both instances are compared every cycle against a packet-level reference model. The
// model keeps the skid buffer as a queue.
module tb_router_reg_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pkt_valid, fifo_full, rst_int_reg;
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic [15:0] din;

  logic [7:0]  dout_a;
  logic        vld_a, pd_a, lpv_a, err_a, ovf_a;
  logic [1:0]  cnt_a;
  logic [15:0] dout_b;
  logic        vld_b, pd_b, lpv_b, err_b, ovf_b;
  logic [1:0]  cnt_b;

  router_reg_param u_dut_a (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .data_in(din[7:0]), .dout(dout_a), .dout_vld(vld_a), .parity_done(pd_a),
    .low_pkt_valid(lpv_a), .err(err_a), .skid_cnt(cnt_a), .skid_ovf(ovf_a));

  router_reg_param #(.DATA_W(16), .SKID_DEPTH(3), .CHK_MODE(1)) u_dut_b (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .data_in(din), .dout(dout_b), .dout_vld(vld_b), .parity_done(pd_b),
    .low_pkt_valid(lpv_b), .err(err_b), .skid_cnt(cnt_b), .skid_ovf(ovf_b));

  int n_vec = 0, n_bad = 0;

  // reference model state, index 0 = instance a, 1 = instance b
  logic [15:0] m_dout[2], m_hdr[2], m_int[2], m_par[2];
  bit          m_vld[2], m_pd[2], m_lpv[2], m_err[2], m_ovf[2];
  logic [15:0] sk0[$], sk1[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] csum(input int i, input logic [15:0] a, input logic [15:0] b);
    if (i == 1) return a + b;
    return (a ^ b) & 16'h00FF;
  endfunction

  task automatic mdl(input int i);
    logic [15:0] d, o_int, o_par;
    bit o_pd, o_lpv, o_ovf, pd_set;
    int dep, sz;
    d     = (i == 1) ? din : {8'h00, din[7:0]};
    dep   = (i == 1) ? 3 : 2;
    sz    = (i == 1) ? sk1.size() : sk0.size();
    o_int = m_int[i]; o_par = m_par[i]; o_pd = m_pd[i]; o_lpv = m_lpv[i]; o_ovf = m_ovf[i];
    if (!rst) begin
      m_dout[i] = 0; m_hdr[i] = 0; m_int[i] = 0; m_par[i] = 0;
      m_vld[i] = 0; m_pd[i] = 0; m_lpv[i] = 0; m_err[i] = 0; m_ovf[i] = 0;
      if (i == 1) sk1.delete(); else sk0.delete();
      return;
    end
    m_vld[i] = 0;
    m_lpv[i] = rst_int_reg ? 1'b0 : (ld_state && !pkt_valid);
    pd_set   = (ld_state && !pkt_valid && !fifo_full) || (laf_state && o_lpv && !o_pd);
    if (detect_add) begin
      if (pkt_valid && d[1:0] < 2'd3) m_hdr[i] = d;
      m_int[i] = 0; m_par[i] = 0; m_pd[i] = 0; m_err[i] = 0; m_ovf[i] = 0;
      if (i == 1) sk1.delete(); else sk0.delete();
    end else begin
      if (lfd_state) begin
        m_dout[i] = m_hdr[i]; m_vld[i] = 1;
        m_int[i] = csum(i, o_int, m_hdr[i]);
      end else if (ld_state && !fifo_full) begin
        m_dout[i] = d; m_vld[i] = 1;
      end else if (ld_state) begin
        if (sz == dep) m_ovf[i] = 1;
        else if (i == 1) sk1.push_back(d);
        else sk0.push_back(d);
      end else if (laf_state && sz > 0) begin
        m_dout[i] = (i == 1) ? sk1.pop_front() : sk0.pop_front();
        m_vld[i] = 1;
      end
      if (pkt_valid && ld_state && !full_state) m_int[i] = csum(i, o_int, d);
      if (ld_state && !pkt_valid) m_par[i] = d;
      if (o_pd) m_err[i] = (o_par != o_int) || o_ovf;
    end
    if (pd_set) m_pd[i] = 1;
  endtask

  task automatic step();
    @(posedge clk);
    mdl(0); mdl(1);
    #1;
    chk_eq("dout_a", 32'(dout_a), 32'(m_dout[0]));
    chk_eq("vld_a",  32'(vld_a),  32'(m_vld[0]));
    chk_eq("pd_a",   32'(pd_a),   32'(m_pd[0]));
    chk_eq("lpv_a",  32'(lpv_a),  32'(m_lpv[0]));
    chk_eq("err_a",  32'(err_a),  32'(m_err[0]));
    chk_eq("ovf_a",  32'(ovf_a),  32'(m_ovf[0]));
    chk_eq("cnt_a",  32'(cnt_a),  32'(sk0.size()));
    chk_eq("dout_b", 32'(dout_b), 32'(m_dout[1]));
    chk_eq("vld_b",  32'(vld_b),  32'(m_vld[1]));
    chk_eq("pd_b",   32'(pd_b),   32'(m_pd[1]));
    chk_eq("lpv_b",  32'(lpv_b),  32'(m_lpv[1]));
    chk_eq("err_b",  32'(err_b),  32'(m_err[1]));
    chk_eq("ovf_b",  32'(ovf_b),  32'(m_ovf[1]));
    chk_eq("cnt_b",  32'(cnt_b),  32'(sk1.size()));
  endtask

  task automatic drv(input bit da, input bit lf, input bit l, input bit la, input bit fs,
                     input bit pv, input bit ff, input logic [15:0] d);
    detect_add = da; lfd_state = lf; ld_state = l; laf_state = la; full_state = fs;
    pkt_valid = pv; fifo_full = ff; din = d;
  endtask

  // detect_add, lfd, payload (ffm/fsm give per-byte fifo_full/full_state), parity byte,
  // laf_n drain cycles, then one idle cycle with rst_int_reg. rst_at aborts with a reset.
  task automatic send_pkt(input logic [15:0] hdr, input logic [15:0] pl[$], input logic [15:0] par,
                          input logic [7:0] ffm, input logic [7:0] fsm, input int laf_n,
                          input int rst_at);
    drv(1, 0, 0, 0, 0, 1, 0, hdr); step();
    drv(0, 1, 0, 0, 0, 1, 0, hdr); step();
    for (int k = 0; k < pl.size(); k++) begin
      drv(0, 0, 1, 0, fsm[k], 1, ffm[k], pl[k]);
      if (k == rst_at) begin
        rst = 1'b0; step(); rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 16'h0);
        return;
      end
      step();
    end
    drv(0, 0, 1, 0, 0, 0, ffm[pl.size()], par); step();
    for (int k = 0; k < laf_n; k++) begin
      drv(0, 0, 0, 1, 0, 0, 0, 16'h0); step();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 16'h0); rst_int_reg = 1'b1; step(); rst_int_reg = 1'b0;
  endtask

  initial begin
    logic [15:0] pl[$];
    logic [15:0] hdr, par;
    logic [7:0]  ffm, fsm;
    int n;

    rst = 1'b0; rst_int_reg = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 16'h0);
    step(); step();
    rst = 1'b1;

    // T1: good 3-byte packet
    pl = '{16'h11, 16'h22};
    send_pkt(16'h09, pl, 16'h3A, 8'h0, 8'h0, 2, -1);
    chk_eq("t1_err", 32'(err_a), 32'd0);
    chk_eq("t1_pd", 32'(pd_a), 32'd1);

    // T2: bad parity, then detect_add clears err/parity_done
    send_pkt(16'h09, pl, 16'h3B, 8'h0, 8'h0, 2, -1);
    chk_eq("t2_err", 32'(err_a), 32'd1);
    drv(1, 0, 0, 0, 0, 1, 0, 16'h09); step();
    chk_eq("t2_clr_err", 32'(err_a), 32'd0);
    chk_eq("t2_clr_pd", 32'(pd_a), 32'd0);

    // T3: payload parked in skid, drained in order
    send_pkt(16'h09, pl, 16'h3A, 8'b011, 8'h0, 2, -1);
    chk_eq("t3_cnt", 32'(cnt_a), 32'd0);
    chk_eq("t3_dout", 32'(dout_a), 32'h22);
    chk_eq("t3_err", 32'(err_a), 32'd0);

    // T4: three bytes while full into a depth-2 skid
    pl = '{16'h11, 16'h22, 16'h33};
    send_pkt(16'h09, pl, 16'h09, 8'b0111, 8'h0, 0, -1);
    chk_eq("t4_ovf", 32'(ovf_a), 32'd1);
    chk_eq("t4_cnt", 32'(cnt_a), 32'd2);
    chk_eq("t4_err", 32'(err_a), 32'd1);

    // T5: additive 16-bit wrap
    pl = '{16'hFFFF, 16'h0002};
    send_pkt(16'h0001, pl, 16'h0002, 8'h0, 8'h0, 1, -1);
    chk_eq("t5_err_b", 32'(err_b), 32'd0);

    // T6: invalid address is not captured; then reset mid-payload
    drv(1, 0, 0, 0, 0, 1, 0, 16'h000B); step();
    drv(0, 1, 0, 0, 0, 1, 0, 16'h000B); step();
    chk_eq("t6_hdr_a", 32'(dout_a), 32'h01);
    chk_eq("t6_hdr_b", 32'(dout_b), 32'h0001);
    pl = '{16'h11, 16'h22, 16'h33};
    send_pkt(16'h09, pl, 16'h09, 8'b0001, 8'h0, 2, 1);
    chk_eq("t6_rst_dout", 32'(dout_a), 32'd0);
    chk_eq("t6_rst_cnt", 32'(cnt_a), 32'd0);

    // randomized packets
    for (int p = 0; p < 150; p++) begin
      n   = $urandom_range(1, 5);
      hdr = 16'($urandom);
      par = {8'h00, hdr[7:0]};
      pl.delete();
      for (int k = 0; k < n; k++) begin
        pl.push_back(16'($urandom));
        par[7:0] = par[7:0] ^ pl[k][7:0];
      end
      if ($urandom_range(0, 3) == 0) par = par ^ 16'($urandom_range(1, 255));
      ffm = '0; fsm = '0;
      for (int k = 0; k <= n; k++) begin
        ffm[k] = ($urandom_range(0, 9) < 3);
        fsm[k] = ($urandom_range(0, 19) == 0);
      end
      send_pkt(hdr, pl, par, ffm, fsm, $urandom_range(0, 4),
               ($urandom_range(0, 29) == 0) ? $urandom_range(0, n - 1) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
